// File: rtl/reservation_station_pkg.sv
// Shared types for the dispatch-to-RS interface and the RS-to-FU issue packet.
package reservation_station_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam int FUNC_LEN    = 4;

  typedef enum logic [1:0] {
    FU_ALU,
    FU_MULT,
    FU_BTU,
    FU_LSU
  } fu_e;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag_dest;
    logic [ROB_TAG_LEN-1:0] tag_src1;
    logic [ROB_TAG_LEN-1:0] tag_src2;
    logic                   ready_src1;
    logic                   ready_src2;
    logic [XLEN-1:0]        value_src1;
    logic [XLEN-1:0]        value_src2;
    logic [FUNC_LEN-1:0]    func;
    logic [2:0]             func3;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        npc;
    logic [ROB_TAG_LEN-1:0] insn_tag;
    logic                   halt;
  } inst_rs_t;

  typedef struct packed {
    logic [FUNC_LEN-1:0]    func;
    logic [2:0]             func3;
    logic [XLEN-1:0]        value_src1;
    logic [XLEN-1:0]        value_src2;
    logic [ROB_TAG_LEN-1:0] tag_dest;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        npc;
    logic [ROB_TAG_LEN-1:0] insn_tag;
    logic                   halt;
  } rs_issue_pkt_t;

  // The FU only needs resolved operands, so the source tags and ready bits are dropped here.
  function automatic rs_issue_pkt_t to_issue_pkt(input inst_rs_t inst);
    rs_issue_pkt_t pkt;
    pkt.func       = inst.func;
    pkt.func3      = inst.func3;
    pkt.value_src1 = inst.value_src1;
    pkt.value_src2 = inst.value_src2;
    pkt.tag_dest   = inst.tag_dest;
    pkt.imm        = inst.imm;
    pkt.pc         = inst.pc;
    pkt.npc        = inst.npc;
    pkt.insn_tag   = inst.insn_tag;
    pkt.halt       = inst.halt;
    return pkt;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Oldest-ready picker: among ready entries, grants the one with the smallest age.
module rs_select #(
  parameter int RS_DEPTH   = 4,
  parameter int RS_IDX_LEN = $clog2(RS_DEPTH)
) (
  input  logic [RS_DEPTH-1:0]                 ready,
  input  logic [RS_DEPTH-1:0][RS_IDX_LEN:0]   age,
  output logic [RS_DEPTH-1:0]                 grant,
  output logic [RS_IDX_LEN-1:0]               grant_idx,
  output logic                                any_ready
);

  logic [RS_IDX_LEN:0] best_age;

  // Ages of valid entries are unique, so a strict compare never ties.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_ready = 1'b0;
    best_age  = '1;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready[i] && (!any_ready || age[i] < best_age)) begin
        any_ready = 1'b1;
        best_age  = age[i];
        grant_idx = RS_IDX_LEN'(i);
      end
    end
    if (any_ready) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/reservation_station.sv
// Per-FU reservation station: allocates dispatched packets, snoops the CDB, issues oldest-ready first.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_DEPTH   = 4,
  parameter int RS_IDX_LEN = $clog2(RS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  inst_rs_t               inst_in,
  output logic                   is_full,
  input  logic                   cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  input  logic                   flush,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output rs_issue_pkt_t          issue_pkt
);

  localparam logic [RS_IDX_LEN:0] AGE_ONE = 1;

  logic [RS_DEPTH-1:0]               valid;
  logic [RS_DEPTH-1:0][RS_IDX_LEN:0] age;
  inst_rs_t                          entry [RS_DEPTH];

  logic [RS_DEPTH-1:0]   ready_vec;
  logic [RS_DEPTH-1:0]   grant;
  logic [RS_IDX_LEN-1:0] grant_idx;
  logic                  any_ready;
  logic                  fire;
  logic [RS_IDX_LEN:0]   freed_age;
  logic [RS_IDX_LEN-1:0] alloc_idx;
  logic                  alloc_found;
  logic                  alloc_en;
  logic [RS_IDX_LEN:0]   valid_count;
  logic [RS_IDX_LEN:0]   new_age;
  inst_rs_t              inst_bp;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = valid[i] & entry[i].ready_src1 & entry[i].ready_src2;
    end
  end

  rs_select #(
    .RS_DEPTH   (RS_DEPTH),
    .RS_IDX_LEN (RS_IDX_LEN)
  ) u_select (
    .ready     (ready_vec),
    .age       (age),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_ready (any_ready)
  );

  assign is_full     = &valid;
  assign issue_valid = any_ready;
  assign fire        = issue_valid & issue_ready;
  assign freed_age   = age[grant_idx];

  always_comb begin
    issue_pkt = '0;
    if (any_ready) issue_pkt = to_issue_pkt(entry[grant_idx]);
  end

  // Allocation looks only at pre-update valid bits, so a slot freed this cycle is not reused yet.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    valid_count = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid_count = valid_count + {{RS_IDX_LEN{1'b0}}, valid[i]};
      if (!valid[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = RS_IDX_LEN'(i);
      end
    end
  end

  assign alloc_en = load & alloc_found;
  // The newcomer is younger than whatever issues this cycle, so it shifts down with the rest.
  assign new_age  = fire ? valid_count - AGE_ONE : valid_count;

  // Capture a CDB broadcast that coincides with dispatch so the wakeup is not missed.
  always_comb begin
    inst_bp = inst_in;
    if (cdb_valid && !inst_in.ready_src1 && inst_in.tag_src1 == cdb_tag) begin
      inst_bp.ready_src1 = 1'b1;
      inst_bp.value_src1 = cdb_value;
    end
    if (cdb_valid && !inst_in.ready_src2 && inst_in.tag_src2 == cdb_tag) begin
      inst_bp.ready_src2 = 1'b1;
      inst_bp.value_src2 = cdb_value;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      age   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) entry[i] <= '0;
    end else if (flush) begin
      valid <= '0;
      age   <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid[i]) begin
          if (cdb_valid && !entry[i].ready_src1 && entry[i].tag_src1 == cdb_tag) begin
            entry[i].ready_src1 <= 1'b1;
            entry[i].value_src1 <= cdb_value;
          end
          if (cdb_valid && !entry[i].ready_src2 && entry[i].tag_src2 == cdb_tag) begin
            entry[i].ready_src2 <= 1'b1;
            entry[i].value_src2 <= cdb_value;
          end
          if (fire && age[i] > freed_age) age[i] <= age[i] - AGE_ONE;
        end
        if (fire && grant[i]) valid[i] <= 1'b0;
      end
      if (alloc_en) begin
        entry[alloc_idx] <= inst_bp;
        valid[alloc_idx] <= 1'b1;
        age[alloc_idx]   <= new_age;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected issues are queued at stimulus time.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   load = 1'b0;
  inst_rs_t               inst_in = '0;
  logic                   is_full;
  logic                   cdb_valid = 1'b0;
  logic [ROB_TAG_LEN-1:0] cdb_tag = '0;
  logic [XLEN-1:0]        cdb_value = '0;
  logic                   flush = 1'b0;
  logic                   issue_valid;
  logic                   issue_ready = 1'b0;
  rs_issue_pkt_t          issue_pkt;

  typedef struct {
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        v1;
    logic [XLEN-1:0]        v2;
    logic [XLEN-1:0]        pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  reservation_station dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .inst_in     (inst_in),
    .is_full     (is_full),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_pkt   (issue_pkt)
  );

  always #5 clk = ~clk;

  function automatic inst_rs_t mk_inst(input int td, input int ts1, input bit r1, input int v1,
                                       input int ts2, input bit r2, input int v2);
    inst_rs_t p;
    p            = '0;
    p.tag_dest   = ROB_TAG_LEN'(td);
    p.tag_src1   = ROB_TAG_LEN'(ts1);
    p.ready_src1 = r1;
    p.value_src1 = XLEN'(v1);
    p.tag_src2   = ROB_TAG_LEN'(ts2);
    p.ready_src2 = r2;
    p.value_src2 = XLEN'(v2);
    p.func       = 4'h3;
    p.func3      = 3'h1;
    p.pc         = XLEN'(32'h1000 + td * 4);
    p.npc        = XLEN'(32'h1004 + td * 4);
    p.insn_tag   = ROB_TAG_LEN'(td);
    return p;
  endfunction

  function automatic exp_t mk_exp(input int td, input int v1, input int v2);
    exp_t x;
    x.tag = ROB_TAG_LEN'(td);
    x.v1  = XLEN'(v1);
    x.v2  = XLEN'(v2);
    x.pc  = XLEN'(32'h1000 + td * 4);
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Dispatch never loads a full RS; doing so here would be a bench bug.
  task automatic drive_load(input inst_rs_t p);
    if (is_full) begin
      failures++;
      $display("[TB] FAIL load_protocol: load while is_full=%0d required 0", is_full);
    end
    inst_in = p;
    load    = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_issue_valid: got %b required 0", issue_valid);
    end
    checks++;
    if (is_full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_is_full: got %b required 0", is_full);
    end
    checks++;
    if (issue_pkt !== '0) begin
      failures++;
      $display("[TB] FAIL reset_issue_pkt: got %h required 0", issue_pkt);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive_load(mk_inst(5, 0, 1'b1, 3, 0, 1'b1, 4));
    exp_q.push_back(mk_exp(5, 3, 4));
    step();
    load = 1'b0;
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_valid: got %b required 1", issue_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (issue_pkt.tag_dest !== e.tag || issue_pkt.value_src1 !== e.v1 ||
          issue_pkt.value_src2 !== e.v2 || issue_pkt.pc !== e.pc) begin
        failures++;
        $display("[TB] FAIL basic_pkt: got tag=%0d v1=%h v2=%h pc=%h required tag=%0d v1=%h v2=%h pc=%h",
                 issue_pkt.tag_dest, issue_pkt.value_src1, issue_pkt.value_src2, issue_pkt.pc,
                 e.tag, e.v1, e.v2, e.pc);
      end
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_drained: got %b required 0", issue_valid);
    end
  endtask

  task automatic test_wakeup();
    drive_load(mk_inst(6, 2, 1'b0, 0, 0, 1'b1, 1));
    step();
    load      = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 5'd2;
    cdb_value = 32'hAA;
    exp_q.push_back(mk_exp(6, 32'hAA, 1));
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wakeup_early: got issue_valid=%b required 0", issue_valid);
    end
    step();
    cdb_valid = 1'b0;
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wakeup_valid: got %b required 1", issue_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (issue_pkt.tag_dest !== e.tag || issue_pkt.value_src1 !== e.v1 ||
          issue_pkt.value_src2 !== e.v2 || issue_pkt.pc !== e.pc) begin
        failures++;
        $display("[TB] FAIL wakeup_pkt: got tag=%0d v1=%h v2=%h pc=%h required tag=%0d v1=%h v2=%h pc=%h",
                 issue_pkt.tag_dest, issue_pkt.value_src1, issue_pkt.value_src2, issue_pkt.pc,
                 e.tag, e.v1, e.v2, e.pc);
      end
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
  endtask

  task automatic test_bypass();
    drive_load(mk_inst(7, 0, 1'b1, 2, 7, 1'b0, 0));
    cdb_valid = 1'b1;
    cdb_tag   = 5'd7;
    cdb_value = 32'h55;
    exp_q.push_back(mk_exp(7, 2, 32'h55));
    step();
    load      = 1'b0;
    cdb_valid = 1'b0;
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bypass_valid: got %b required 1", issue_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (issue_pkt.tag_dest !== e.tag || issue_pkt.value_src1 !== e.v1 ||
          issue_pkt.value_src2 !== e.v2 || issue_pkt.pc !== e.pc) begin
        failures++;
        $display("[TB] FAIL bypass_pkt: got tag=%0d v1=%h v2=%h pc=%h required tag=%0d v1=%h v2=%h pc=%h",
                 issue_pkt.tag_dest, issue_pkt.value_src1, issue_pkt.value_src2, issue_pkt.pc,
                 e.tag, e.v1, e.v2, e.pc);
      end
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    for (int k = 1; k <= 4; k++) begin
      drive_load(mk_inst(k, 0, 1'b1, k * 16, 0, 1'b1, k * 16 + 1));
      exp_q.push_back(mk_exp(k, k * 16, k * 16 + 1));
      step();
      load = 1'b0;
    end
    checks++;
    if (is_full !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fill_is_full: got %b required 1", is_full);
    end
    step();
    checks++;
    if (issue_pkt.tag_dest !== 5'd1) begin
      failures++;
      $display("[TB] FAIL fill_stable: got tag=%0d required 1", issue_pkt.tag_dest);
    end
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL fill_order_valid: got issue_valid=%b queued=%0d required 1", issue_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (issue_pkt.tag_dest !== e.tag || issue_pkt.value_src1 !== e.v1 ||
            issue_pkt.value_src2 !== e.v2 || issue_pkt.pc !== e.pc) begin
          failures++;
          $display("[TB] FAIL fill_order: got tag=%0d v1=%h v2=%h pc=%h required tag=%0d v1=%h v2=%h pc=%h",
                   issue_pkt.tag_dest, issue_pkt.value_src1, issue_pkt.value_src2, issue_pkt.pc,
                   e.tag, e.v1, e.v2, e.pc);
        end
      end
      step();
      if (k == 0) begin
        checks++;
        if (is_full !== 1'b0) begin
          failures++;
          $display("[TB] FAIL fill_not_full: got %b required 0", is_full);
        end
      end
    end
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_drained: got %b required 0", issue_valid);
    end
  endtask

  task automatic test_oldest_first();
    // A waits on ROB tag 9 while younger B is ready.
    drive_load(mk_inst(1, 9, 1'b0, 0, 0, 1'b1, 0));
    step();
    drive_load(mk_inst(2, 0, 1'b1, 32'h21, 0, 1'b1, 32'h22));
    exp_q.push_back(mk_exp(2, 32'h21, 32'h22));
    step();
    load = 1'b0;
    checks++;
    if (issue_valid !== 1'b1 || issue_pkt.tag_dest !== 5'd2) begin
      failures++;
      $display("[TB] FAIL oldest_young_ready: got valid=%b tag=%0d required valid=1 tag=2", issue_valid, issue_pkt.tag_dest);
    end else void'(exp_q.pop_front());
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oldest_a_waiting: got %b required 0", issue_valid);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 5'd9;
    cdb_value = 32'h99;
    exp_q.push_back(mk_exp(1, 32'h99, 0));
    step();
    cdb_valid = 1'b0;
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oldest_a_valid: got %b required 1", issue_valid);
    end else begin
      e = exp_q.pop_front();
      if (issue_pkt.tag_dest !== e.tag || issue_pkt.value_src1 !== e.v1 || issue_pkt.pc !== e.pc) begin
        failures++;
        $display("[TB] FAIL oldest_a_pkt: got tag=%0d v1=%h pc=%h required tag=%0d v1=%h pc=%h",
                 issue_pkt.tag_dest, issue_pkt.value_src1, issue_pkt.pc, e.tag, e.v1, e.pc);
      end
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;

    // Older Q sits in a higher slot than younger R and must still win once woken.
    drive_load(mk_inst(4, 0, 1'b1, 32'h41, 0, 1'b1, 32'h42));
    step();
    drive_load(mk_inst(5, 12, 1'b0, 0, 0, 1'b1, 32'h52));
    step();
    load = 1'b0;
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    drive_load(mk_inst(6, 0, 1'b1, 32'h61, 0, 1'b1, 32'h62));
    step();
    load = 1'b0;
    checks++;
    if (issue_valid !== 1'b1 || issue_pkt.tag_dest !== 5'd6) begin
      failures++;
      $display("[TB] FAIL age_young_shown: got valid=%b tag=%0d required valid=1 tag=6", issue_valid, issue_pkt.tag_dest);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 5'd12;
    cdb_value = 32'h51;
    exp_q.push_back(mk_exp(5, 32'h51, 32'h52));
    exp_q.push_back(mk_exp(6, 32'h61, 32'h62));
    step();
    cdb_valid   = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL age_order_valid: got issue_valid=%b queued=%0d required 1", issue_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (issue_pkt.tag_dest !== e.tag || issue_pkt.value_src1 !== e.v1 ||
            issue_pkt.value_src2 !== e.v2 || issue_pkt.pc !== e.pc) begin
          failures++;
          $display("[TB] FAIL age_order: got tag=%0d v1=%h v2=%h pc=%h required tag=%0d v1=%h v2=%h pc=%h",
                   issue_pkt.tag_dest, issue_pkt.value_src1, issue_pkt.value_src2, issue_pkt.pc,
                   e.tag, e.v1, e.v2, e.pc);
        end
      end
      step();
    end
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL age_drained: got %b required 0", issue_valid);
    end
  endtask

  task automatic test_flush();
    for (int k = 8; k <= 10; k++) begin
      drive_load(mk_inst(k, 0, 1'b1, k, 0, 1'b1, k));
      step();
      load = 1'b0;
    end
    checks++;
    if (issue_valid !== 1'b1 || issue_pkt.tag_dest !== 5'd8) begin
      failures++;
      $display("[TB] FAIL flush_pre: got valid=%b tag=%0d required valid=1 tag=8", issue_valid, issue_pkt.tag_dest);
    end
    flush = 1'b1;
    drive_load(mk_inst(11, 0, 1'b1, 11, 0, 1'b1, 11));
    step();
    flush = 1'b0;
    load  = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || is_full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_clear: got valid=%b full=%b required 0 0", issue_valid, is_full);
    end
    step();
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_load_dropped: got valid=%b tag=%0d required 0", issue_valid, issue_pkt.tag_dest);
    end
  endtask

  task automatic test_reset_mid();
    drive_load(mk_inst(3, 0, 1'b1, 7, 0, 1'b1, 8));
    step();
    load = 1'b0;
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_pre: got %b required 1", issue_valid);
    end
    issue_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (issue_valid !== 1'b0 || is_full !== 1'b0 || issue_pkt !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_async: got valid=%b full=%b pkt=%h required all 0", issue_valid, is_full, issue_pkt);
    end
    @(negedge clk);
    issue_ready = 1'b0;
    reset_n     = 1'b1;
    step();
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_after: got %b required 0", issue_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_fill_backpressure();
    test_oldest_first();
    test_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
